// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of a combinational 4-bit ALU. Commands are issued into
// registered operand lines, and the result is captured one cycle after issue.
module alu_cmd_queue #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [3:0]    wr_a_i,
  input  logic [3:0]    wr_b_i,
  input  logic [3:0]    wr_sel_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  input  logic          issue_en_i,
  input  logic          flush_i,
  output logic [3:0]    alu_a_o,
  output logic [3:0]    alu_b_o,
  output logic [3:0]    alu_sel_o,
  input  logic          alu_c_i,
  input  logic [3:0]    alu_out1_i,
  input  logic [3:0]    alu_out2_i,
  output logic          res_valid_o,
  output logic [8:0]    res_data_o,
  output logic [3:0]    res_sel_o,
  output logic          ovf_o,
  output logic          unf_o
);

  logic [11:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q;
  logic [3:0]    alu_a_q, alu_b_q, alu_sel_q;
  logic          issued_q;
  logic          res_valid_q;
  logic [8:0]    res_data_q;
  logic [3:0]    res_sel_q;
  logic          ovf_q, unf_q;

  logic          pop_acc_s, push_acc_s, ovf_set_s, unf_set_s;

  // A pop while full frees the slot the same-cycle push needs; flush masks both.
  always_comb begin
    pop_acc_s  = issue_en_i && !empty_q && !flush_i;
    push_acc_s = wr_en_i && !flush_i && (!full_q || pop_acc_s);
    ovf_set_s  = wr_en_i && !flush_i && full_q && !pop_acc_s;
    unf_set_s  = issue_en_i && !flush_i && empty_q;
    count_d    = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({push_acc_s, pop_acc_s})
        2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
        2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 12'h000;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      alu_a_q     <= 4'h0;
      alu_b_q     <= 4'h0;
      alu_sel_q   <= 4'h0;
      issued_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= 9'h000;
      res_sel_q   <= 4'h0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
      if (flush_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push_acc_s) begin
          mem_q[wptr_q] <= {wr_sel_i, wr_b_i, wr_a_i};
          wptr_q        <= wptr_q + {{(AW-1){1'b0}}, 1'b1};
        end
        if (pop_acc_s) begin
          {alu_sel_q, alu_b_q, alu_a_q} <= mem_q[rptr_q];
          rptr_q <= rptr_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      // An issue in flight survives a flush; only reset drops it.
      issued_q    <= pop_acc_s;
      res_valid_q <= issued_q;
      if (issued_q) begin
        res_data_q <= {alu_c_i, alu_out2_i, alu_out1_i};
        res_sel_q  <= alu_sel_q;
      end
      if (ovf_set_s) ovf_q <= 1'b1;
      if (unf_set_s) unf_q <= 1'b1;
    end
  end

  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign count_o     = count_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_sel_o   = alu_sel_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_sel_o   = res_sel_q;
  assign ovf_o       = ovf_q;
  assign unf_o       = unf_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue: expected results are queued at issue time
// and a negedge monitor compares every res_valid strobe against them.
module tb_alu_cmd_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, issue_en, flush;
  logic [3:0] wr_a, wr_b, wr_sel;
  logic       full, empty;
  logic [3:0] count;
  logic [3:0] alu_a, alu_b, alu_sel;
  logic       alu_c;
  logic [3:0] alu_out1, alu_out2;
  logic       res_valid;
  logic [8:0] res_data;
  logic [3:0] res_sel;
  logic       ovf, unf;

  int checks = 0;
  int errors = 0;

  logic [12:0] mfifo [$];
  logic [12:0] exp_q [$];
  int          mcnt = 0;

  always #5 clk = ~clk;

  alu_cmd_queue #(.DEPTH(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en), .wr_a_i(wr_a), .wr_b_i(wr_b), .wr_sel_i(wr_sel),
    .full_o(full), .empty_o(empty), .count_o(count),
    .issue_en_i(issue_en), .flush_i(flush),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
    .alu_c_i(alu_c), .alu_out1_i(alu_out1), .alu_out2_i(alu_out2),
    .res_valid_o(res_valid), .res_data_o(res_data), .res_sel_o(res_sel),
    .ovf_o(ovf), .unf_o(unf)
  );

  // Stand-in ALU: SEL 0 add, SEL 1 subtract, SEL 2 8-bit multiply.
  always_comb begin
    logic [7:0] prod;
    logic [4:0] sum;
    prod = 8'h00;
    sum  = 5'h00;
    alu_c = 1'b0; alu_out1 = 4'h0; alu_out2 = 4'h0;
    case (alu_sel)
      4'h0: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; {alu_c, alu_out1} = sum; end
      4'h1: begin sum = {1'b0, alu_a} - {1'b0, alu_b}; {alu_c, alu_out1} = sum; end
      4'h2: begin prod = {4'h0, alu_a} * {4'h0, alu_b}; {alu_out2, alu_out1} = prod; end
      default: begin alu_out1 = 4'h0; end
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: inputs applied at negedge, the bench's expectations advance at posedge.
  task automatic cyc(input bit wr, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] sel, input logic [8:0] res,
                     input bit iss, input bit fl);
    bit pop, push;
    wr_en = wr; wr_a = a; wr_b = b; wr_sel = sel; issue_en = iss; flush = fl;
    @(posedge clk);
    pop  = iss && !fl && (mcnt != 0);
    push = wr && !fl && ((mcnt < 8) || pop);
    if (pop) exp_q.push_back(mfifo.pop_front());
    if (push) mfifo.push_back({sel, res});
    if (fl) begin
      mfifo.delete();
      mcnt = 0;
    end else begin
      mcnt = mcnt + int'(push) - int'(pop);
    end
    @(negedge clk);
    wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 4'h0, 4'h0, 9'h000, 1'b0, 1'b0);
  endtask

  // Every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_res: got sel=%h data=%h with nothing outstanding", res_sel, res_data);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if ({res_sel, res_data} !== e) begin
          errors++;
          $display("FAIL res: got sel=%h data=%h expected sel=%h data=%h",
                   res_sel, res_data, e[12:9], e[8:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    wr_a = 4'h0; wr_b = 4'h0; wr_sel = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_alu", int'({alu_a, alu_b, alu_sel}), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_flags", int'({ovf, unf}), 0);

    // 1 + 1
    cyc(1'b1, 4'd1, 4'd1, 4'b0000, 9'h002, 1'b0, 1'b0);
    chk("push1_count", int'(count), 1);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 9'h000, 1'b1, 1'b0);
    chk("issue1_alu", int'({alu_a, alu_b, alu_sel}), int'({4'd1, 4'd1, 4'd0}));
    idle(1);

    // 1 + 8 then 15 * 3 back to back
    cyc(1'b1, 4'd1, 4'd8, 4'b0000, 9'h009, 1'b0, 1'b0);
    cyc(1'b1, 4'd15, 4'd3, 4'b0010, 9'h02D, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 9'h000, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 9'h000, 1'b1, 1'b0);
    chk("b2b_alu", int'({alu_a, alu_b, alu_sel}), int'({4'd15, 4'd3, 4'b0010}));
    idle(2);

    // Fill: i + i for i = 1..8; 8 + 8 carries out
    for (int i = 1; i <= 8; i++)
      cyc(1'b1, 4'(i), 4'(i), 4'h0, (i == 8) ? 9'h100 : 9'(2 * i), 1'b0, 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 8);
    chk("fill_ovf_clear", int'(ovf), 0);
    cyc(1'b1, 4'd7, 4'd7, 4'h0, 9'h00E, 1'b0, 1'b0);
    chk("push9_ovf", int'(ovf), 1);
    chk("push9_count", int'(count), 8);
    cyc(1'b1, 4'd9, 4'd9, 4'h0, 9'h102, 1'b1, 1'b0);
    chk("full_pushpop_count", int'(count), 8);
    chk("full_pushpop_full", int'(full), 1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'd0, 4'd0, 4'd0, 9'h000, 1'b1, 1'b0);
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(count), 0);
    idle(2);

    // Underflow
    chk("pre_unf", int'(unf), 0);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 9'h000, 1'b1, 1'b0);
    chk("unf_set", int'(unf), 1);
    chk("unf_alu_hold", int'({alu_a, alu_b, alu_sel}), int'({4'd9, 4'd9, 4'd0}));
    idle(2);
    cyc(1'b1, 4'd3, 4'd4, 4'h0, 9'h007, 1'b1, 1'b0);
    chk("empty_pushpop_count", int'(count), 1);
    chk("empty_pushpop_alu", int'(alu_a), 9);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 9'h000, 1'b1, 1'b0);
    chk("late_issue_alu", int'(alu_a), 3);
    idle(2);

    // Reset with an issue in flight
    cyc(1'b1, 4'd2, 4'd2, 4'h0, 9'h004, 1'b0, 1'b0);
    cyc(1'b1, 4'd5, 4'd5, 4'h0, 9'h00A, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 9'h000, 1'b1, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    mfifo.delete();
    mcnt = 0;
    @(negedge clk);
    chk("midrst_alu", int'({alu_a, alu_b, alu_sel}), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_flags", int'({ovf, unf}), 0);
    chk("midrst_valid", int'(res_valid), 0);
    rst_n = 1'b1;
    idle(2);

    // Flush while the first of three is in flight
    cyc(1'b1, 4'd1, 4'd2, 4'h0, 9'h003, 1'b0, 1'b0);
    cyc(1'b1, 4'd2, 4'd3, 4'h0, 9'h005, 1'b0, 1'b0);
    cyc(1'b1, 4'd4, 4'd4, 4'h0, 9'h008, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 9'h000, 1'b1, 1'b0);
    cyc(1'b1, 4'd7, 4'd7, 4'h0, 9'h00E, 1'b1, 1'b1);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_flags", int'({ovf, unf}), 0);
    idle(1);
    cyc(1'b1, 4'd6, 4'd1, 4'h1, 9'h005, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 4'd0, 4'd0, 9'h000, 1'b1, 1'b0);
    idle(3);
    chk("outstanding_results", exp_q.size(), 0);
    chk("final_count", int'(count), mcnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
